// File: rtl/uart_rx_deserializer.sv
// UART receive engine: oversampled start detect, 5-8 data bits LSB-first,
// optional parity and 1/2 stop bits, one-cycle valid pulse with error flags.
module uart_rx_deserializer #(
    parameter int SAMPLING_RATE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_en_i,
    input  logic       tick_i,
    input  logic       rx_i,
    input  logic [1:0] data_bit_num_i,
    input  logic       parity_en_i,
    input  logic       parity_type_i,
    input  logic       stop_bit_num_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic       parity_err_o,
    output logic       stop_bit_err_o,
    output logic       busy_o
);
    localparam int CW = $clog2(SAMPLING_RATE);
    localparam logic [CW-1:0] CNT_MID = CW'(SAMPLING_RATE / 2 - 1);
    localparam logic [CW-1:0] CNT_END = CW'(SAMPLING_RATE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_nxt;

    logic          rx_meta, rx_s, rx_s_d;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [1:0]    cfg_bits;
    logic          cfg_par_en, cfg_par_odd, cfg_stop2;
    logic          stop_idx, par_err, stop_err;
    logic          start_edge, mid_tick, bit_tick, last_bit, last_stop, frame_done;

    assign start_edge = rx_en_i && rx_s_d && !rx_s;
    assign mid_tick   = tick_i && (cnt == CNT_MID);
    assign bit_tick   = tick_i && (cnt == CNT_END);
    // last data bit index is N-1 = 4 + cfg_bits
    assign last_bit   = (bit_idx == {1'b1, cfg_bits});
    assign last_stop  = (stop_idx == cfg_stop2);
    assign frame_done = rx_en_i && (state == STOP) && bit_tick && last_stop;
    assign busy_o     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start_edge) state_nxt = START;
            START:  if (mid_tick) state_nxt = rx_s ? IDLE : DATA;
            DATA:   if (bit_tick && last_bit) state_nxt = cfg_par_en ? PARITY : STOP;
            PARITY: if (bit_tick) state_nxt = STOP;
            STOP:   if (bit_tick && last_stop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!rx_en_i) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rx_meta        <= 1'b1;
            rx_s           <= 1'b1;
            rx_s_d         <= 1'b1;
            cnt            <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            cfg_bits       <= '0;
            cfg_par_en     <= 1'b0;
            cfg_par_odd    <= 1'b0;
            cfg_stop2      <= 1'b0;
            stop_idx       <= 1'b0;
            par_err        <= 1'b0;
            stop_err       <= 1'b0;
            data_o         <= '0;
            data_valid_o   <= 1'b0;
            parity_err_o   <= 1'b0;
            stop_bit_err_o <= 1'b0;
        end else begin
            state   <= state_nxt;
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;

            // counter restarts on every state entry and after each bit sample
            if (state == IDLE || state_nxt != state || bit_tick)
                cnt <= '0;
            else if (tick_i)
                cnt <= cnt + CW'(1);

            data_valid_o <= frame_done;

            case (state)
                IDLE: if (start_edge) begin
                    cfg_bits    <= data_bit_num_i;
                    cfg_par_en  <= parity_en_i;
                    cfg_par_odd <= parity_type_i;
                    cfg_stop2   <= stop_bit_num_i;
                end
                START: if (mid_tick && !rx_s) begin
                    bit_idx  <= '0;
                    shreg    <= '0;
                    stop_idx <= 1'b0;
                    par_err  <= 1'b0;
                    stop_err <= 1'b0;
                end
                DATA: if (bit_tick) begin
                    shreg   <= {rx_s, shreg[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
                PARITY: if (bit_tick)
                    par_err <= ((^shreg) ^ rx_s) != cfg_par_odd;
                STOP: if (bit_tick) begin
                    stop_idx <= 1'b1;
                    if (!rx_s) stop_err <= 1'b1;
                    if (frame_done) begin
                        // LSB-first shifting leaves N bits at the top; right-align them
                        data_o         <= shreg >> (2'd3 - cfg_bits);
                        parity_err_o   <= par_err;
                        stop_bit_err_o <= stop_err | ~rx_s;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench: stimulus serializes frames and queues the expected character;
// a monitor pops and compares on every data_valid_o pulse and checks output hold.
module tb_uart_rx_deserializer;
    localparam int SR   = 16;
    localparam int TDIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_en_i = 1'b0;
    logic       tick_i;
    logic       rx_i = 1'b1;
    logic [1:0] data_bit_num_i = 2'd3;
    logic       parity_en_i = 1'b0;
    logic       parity_type_i = 1'b0;
    logic       stop_bit_num_i = 1'b0;
    logic [7:0] data_o;
    logic       data_valid_o, parity_err_o, stop_bit_err_o, busy_o;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       serr;
    } exp_t;

    exp_t sb[$];
    exp_t hold;
    logic prev_v;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   div = 0;

    uart_rx_deserializer #(.SAMPLING_RATE(SR)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_en_i        (rx_en_i),
        .tick_i         (tick_i),
        .rx_i           (rx_i),
        .data_bit_num_i (data_bit_num_i),
        .parity_en_i    (parity_en_i),
        .parity_type_i  (parity_type_i),
        .stop_bit_num_i (stop_bit_num_i),
        .data_o         (data_o),
        .data_valid_o   (data_valid_o),
        .parity_err_o   (parity_err_o),
        .stop_bit_err_o (stop_bit_err_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (div == TDIV - 1) begin
            div    <= 0;
            tick_i <= 1'b1;
        end else begin
            div    <= div + 1;
            tick_i <= 1'b0;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // monitor: pops on each valid pulse, otherwise outputs must hold the last character
    always @(negedge clk) begin
        if (reset) begin
            hold   = '{8'h00, 1'b0, 1'b0};
            prev_v = 1'b0;
        end else begin
            if (data_valid_o) begin
                chk("valid_single_cycle", int'(prev_v), 0);
                chk("valid_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) hold = sb.pop_front();
            end
            chk("data_o", int'(data_o), int'(hold.data));
            chk("parity_err_o", int'(parity_err_o), int'(hold.perr));
            chk("stop_bit_err_o", int'(stop_bit_err_o), int'(hold.serr));
            prev_v = data_valid_o;
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!tick_i) @(posedge clk);
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        @(negedge clk);
        rx_i = b;
        wait_ticks(n);
    endtask

    // abort: 0 none, 1 rx_en_i drop in data bit 3, 2 reset during parity bit
    task automatic send_frame(input logic [7:0] d, input logic [1:0] nb, input logic pen,
                              input logic podd, input logic st2, input logic pbad,
                              input logic [1:0] stop_vals, input int abort,
                              input logic scramble);
        int         n;
        int         mask;
        logic [7:0] dm;
        logic       pbit;
        exp_t       e;
        n    = 5 + int'(nb);
        mask = (1 << n) - 1;
        dm   = 8'(int'(d) & mask);
        pbit = 1'(($countones(dm) % 2) ^ int'(podd) ^ int'(pbad));
        e.data = dm;
        e.perr = pen && ((($countones(dm) + int'(pbit)) % 2) != int'(podd));
        e.serr = !stop_vals[0] || (st2 && !stop_vals[1]);
        data_bit_num_i = nb;
        parity_en_i    = pen;
        parity_type_i  = podd;
        stop_bit_num_i = st2;
        if (abort == 0) sb.push_back(e);
        drive_bit(1'b0, SR);
        if (scramble) begin
            data_bit_num_i = 2'($urandom);
            parity_en_i    = 1'($urandom);
            parity_type_i  = 1'($urandom);
            stop_bit_num_i = 1'($urandom);
        end
        for (int i = 0; i < n; i++) begin
            if (abort == 1 && i == 3) begin
                drive_bit(dm[i], SR / 2);
                @(negedge clk);
                rx_en_i = 1'b0;
                @(negedge clk);
                chk("abort_en_busy", int'(busy_o), 0);
                chk("abort_en_valid", int'(data_valid_o), 0);
                rx_i    = 1'b1;
                rx_en_i = 1'b1;
                wait_ticks(2 * SR);
                return;
            end
            drive_bit(dm[i], SR);
        end
        if (pen) begin
            if (abort == 2) begin
                drive_bit(pbit, SR / 4);
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                chk("rst_data_o", int'(data_o), 0);
                chk("rst_valid", int'(data_valid_o), 0);
                chk("rst_perr", int'(parity_err_o), 0);
                chk("rst_serr", int'(stop_bit_err_o), 0);
                chk("rst_busy", int'(busy_o), 0);
                reset = 1'b0;
                rx_i  = 1'b1;
                wait_ticks(2 * SR);
                return;
            end
            drive_bit(pbit, SR);
        end
        drive_bit(stop_vals[0], SR);
        if (st2) drive_bit(stop_vals[1], SR);
        chk("busy_after_frame", int'(busy_o), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge clk);
        chk("reset_data_o", int'(data_o), 0);
        chk("reset_valid", int'(data_valid_o), 0);
        chk("reset_perr", int'(parity_err_o), 0);
        chk("reset_serr", int'(stop_bit_err_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        reset   = 1'b0;
        rx_en_i = 1'b1;
        wait_ticks(SR);

        // 8N1 0xA5
        send_frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 0, 1'b0);
        // 7E2 bad parity, then clean frame clears the flag
        send_frame(8'h55, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 0, 1'b0);
        send_frame(8'h2A, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 0, 1'b0);
        // 5O1 back-to-back
        send_frame(8'h1F, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 0, 1'b0);
        send_frame(8'h00, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 0, 1'b0);
        // 8N2 second stop low, then break held for 3 bit periods
        send_frame(8'hC3, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 0, 1'b0);
        wait_ticks(3 * SR);
        drive_bit(1'b1, SR);
        send_frame(8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 0, 1'b0);

        // glitch: 4 ticks low aborts in START
        @(negedge clk);
        rx_i = 1'b0;
        wait_ticks(2);
        chk("glitch_busy_high", int'(busy_o), 1);
        wait_ticks(2);
        @(negedge clk);
        rx_i = 1'b1;
        wait_ticks(SR);
        chk("glitch_busy_low", int'(busy_o), 0);

        // mid-frame aborts, each followed by a good 0x3C
        send_frame(8'h96, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1, 1'b0);
        send_frame(8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 0, 1'b0);
        send_frame(8'h5A, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2, 1'b0);
        send_frame(8'h3C, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 0, 1'b0);

        // randomized frames with config scrambled mid-frame
        for (int k = 0; k < 30; k++) begin
            logic [1:0] sv;
            sv = ($urandom % 5 == 0) ? 2'($urandom) : 2'b11;
            send_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom % 4 == 0), sv, 0, 1'b1);
            if (rx_i == 1'b0) drive_bit(1'b1, SR);
            if ($urandom % 2 == 1) drive_bit(1'b1, $urandom_range(1, 20));
        end

        drive_bit(1'b1, SR);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Bit-level UART receive engine: oversamples the serial line on the baud generator's `tick_i`, detects a start bit, deserializes 5–8 data bits LSB-first, and checks optional parity and 1 or 2 stop bits. It presents each received character as a one-cycle valid pulse with error flags. It sits between the baud generator and the RX FIFO/register logic, and consumes the serial stream produced by the transmit path.

## Interface
- `SAMPLING_RATE`, 16, `tick_i` pulses per bit period; even, ≥ 4.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `rx_en_i` input 1: receiver enable; low forces IDLE.
- `tick_i` input 1: one-`clk` pulse at SAMPLING_RATE × baud.
- `rx_i` input 1: asynchronous serial line, idle high.
- `data_bit_num_i` input 2: 00=5, 01=6, 10=7, 11=8 data bits.
- `parity_en_i` input 1: parity bit present.
- `parity_type_i` input 1: 0=even, 1=odd.
- `stop_bit_num_i` input 1: 0=one stop bit, 1=two stop bits.
- `data_o` output 8: last received character, zero-extended.
- `data_valid_o` output 1: one-cycle pulse, character complete.
- `parity_err_o` output 1: parity mismatch for `data_o`.
- `stop_bit_err_o` output 1: any stop bit sampled low for `data_o`.
- `busy_o` output 1: high in every state except IDLE.

## Operation
- `rx_i` passes through a 2-flop synchronizer; both flops reset to 1. `rx_s` is the second flop and `rx_s_d` is its delayed copy.
- States: IDLE, START, DATA, PARITY, STOP.
- Tick counter `cnt` has width clog2(SAMPLING_RATE). It is cleared on every state entry and increments only on `tick_i`.
- IDLE: when `rx_en_i` & `rx_s_d`=1 & `rx_s`=0 (falling edge), the block latches `data_bit_num_i`, `parity_en_i`, `parity_type_i` and `stop_bit_num_i`, then goes to START. Config changes mid-frame are ignored.
- START: on `tick_i` with `cnt`=SAMPLING_RATE/2−1, sample `rx_s`.
  - 0 → go to DATA, clear the bit index and shift register.
  - 1 → false start; go to IDLE with no output change.
- DATA: on `tick_i` with `cnt`=SAMPLING_RATE−1, shift `rx_s` in LSB-first.
  - After N bits (N=5..8), go to PARITY if parity is enabled, else STOP.
  - Data is right-aligned in the result; bits [7:N] are 0.
- PARITY: same sample point. Error when XOR(data bits, sampled bit) ≠ `parity_type`, i.e. even requires total XOR 0 and odd requires total XOR 1. Go to STOP.
- STOP: same sample point, once or twice per the latched stop count. Any low sample sets the stop error.
  - After the last stop sample, register `data_o`, `parity_err_o` and `stop_bit_err_o`, pulse `data_valid_o`, then go to IDLE. The block returns to IDLE at mid-stop-bit, so back-to-back frames are received.
- After a stop error with the line held low (break), no new frame starts until `rx_s` has been seen high, because IDLE is edge-triggered.
- `rx_en_i` low in any state: go to IDLE next cycle. The partial frame is discarded, no valid pulse is generated, and `data_o` and the flags keep their previous values.
- `data_o`, `parity_err_o` and `stop_bit_err_o` update only on the `data_valid_o` cycle and hold until the next one. Flags are per-character, not sticky.

## Timing
- Reset values: `data_o`=0x00, `data_valid_o`=0, `parity_err_o`=0, `stop_bit_err_o`=0, `busy_o`=0, state=IDLE, `cnt`=0.
- Reset asserted mid-frame returns the block to IDLE on the next edge, with all outputs at reset values.
- Start detection: 2 `clk` after the `rx_i` fall, 3 `clk` until `busy_o` goes high.
- Start bit is sampled SAMPLING_RATE/2 ticks after detection. Each later bit is sampled SAMPLING_RATE ticks after the previous sample.
- `data_valid_o` is high the `clk` after the last stop-sample tick, for exactly 1 cycle; it is never high on consecutive cycles.
- `tick_i` is assumed never high on consecutive `clk` cycles. Each tick advances `cnt` by exactly one.

## Test plan
- 8N1, SAMPLING_RATE=16, send 0xA5 → exactly one `data_valid_o` pulse, `data_o`=0xA5, both error flags 0, `busy_o` low afterwards.
- 7E2, send 0x55 with the parity bit forced to 1 → `data_o`=0x55, `parity_err_o`=1, `stop_bit_err_o`=0. The next correct frame 0x2A clears the flag.
- 5O1, send 0x1F with correct odd parity (parity bit 0), then back-to-back 0x00 (parity bit 1) with no idle gap → two valid pulses: 0x1F then 0x00, no errors.
- 8N2, second stop bit driven low → `data_o` correct, `stop_bit_err_o`=1. With the line then held low for 3 bit periods → no further valid pulse until the line rises and a new start arrives.
- Glitch: `rx_i` low for 4 ticks, then high → `busy_o` pulses, START aborts, no `data_valid_o`, `data_o` unchanged.
- Mid-frame abort: drop `rx_en_i` during DATA bit 3 → IDLE next cycle with no valid pulse. Repeat with `reset` during PARITY → all outputs at reset values. A following 0x3C frame is received correctly in both cases.
